memory_stage: RTL and testbench
===============================

# memory_stage

Memory stage of the 5-stage MIPS32 pipeline: holds the EX/MEM and MEM/WB pipeline registers and runs a variable-latency data-memory request/acknowledge handshake. It takes the execute stage's results and issues loads and stores to data memory. It returns `aluOutMOut` and `resultW` to the execute stage's forwarding multiplexers, and exports its register-write tags to the hazard unit. While a memory access is outstanding, it asserts a stall.

## Interface
- `TIMEOUT`, 255: maximum number of cycles spent waiting for `memAck` before the access is aborted (1..65535).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `regWriteE`, `memToRegE`, `memWriteE` in 1 each: execute-stage control bits.
- `writeRegE` in 5: destination register from execute.
- `aluOutE`, `writeDataE` in 32 each: address/ALU result and store data from execute.
- `flushE` in 1: inserts a bubble into the M register instead of loading the execute-stage inputs.
- `memReq` out 1: data-memory request.
- `memWe` out 1: 1 for a store, 0 for a load.
- `memAddr`, `memWData` out 32 each: request address and store data.
- `memRData` in 32: load data, valid only in a cycle with `memAck`=1.
- `memAck` in 1: request completes in this cycle. May arrive in the same cycle as `memReq`.
- `stallM` out 1: freezes the F/D/E stages and the M register.
- `aluOutMOut` out 32, `writeRegM` out 5, `regWriteM` out 1, `memToRegM` out 1: M-stage state for forwarding and hazard detection.
- `writeRegW` out 5, `regWriteW` out 1, `resultW` out 32: writeback to the register file and forwarding.
- `memErr` out 1: sticky error flag (misaligned access or timeout). Cleared only by reset.

## Operation
- **M register** (`regWriteM`, `memToRegM`, `memWriteM`, `writeRegM`, `aluOutM`, `writeDataM`):
  - Loads the E inputs when `stallM`=0.
  - Loads all-zero (a bubble) when `stallM`=0 and `flushE`=1.
  - Holds its contents when `stallM`=1.
- `aluOutMOut` = `aluOutM`.
- `memOpM` = `memToRegM` | `memWriteM`.
- `misalignM` = `memOpM` & (`aluOutM[1:0]` != 0).
- **FSM states:**
  - IDLE:
    - If `memOpM` & !`misalignM`: drive `memReq`=1, `memWe`=`memWriteM`, `memAddr`=`aluOutM`, `memWData`=`writeDataM` (combinational).
    - If `memAck` is also 1, the access completes with no stall and the FSM stays in IDLE.
    - Otherwise go to WAIT and clear the counter `waitCnt` to 1.
  - WAIT:
    - Keep `memReq`=1 with the address and data unchanged. Increment `waitCnt` each cycle.
    - On `memAck`: complete and go to IDLE.
    - When `waitCnt` == `TIMEOUT` with no ack: abort (`memReq` drops the following cycle), set `memErr`, and go to IDLE.
- `stallM` = `memReq` & !`memAck` & !(WAIT & `waitCnt`==`TIMEOUT`).
- **Misaligned operation:** `memReq` stays 0, no stall, `memErr` is set, and the instruction retires with `regWrite` suppressed in W.
- **MEM/WB register:**
  - When `stallM`=0, it loads `regWriteW` = `regWriteM` & !(aborted | misaligned), plus `memToRegW`, `writeRegW`, `aluOutW`, and `readDataW` = `memRData` (captured on `memAck`).
  - When `stallM`=1, it loads a bubble (`regWriteW`=0).
- `resultW` = `memToRegW` ? `readDataW` : `aluOutW` (combinational).
- A `memAck` while no request is pending is ignored.
- **Reset** clears every register:
  - All outputs are 0 and the FSM is in IDLE.
  - `memReq`=0 and `memErr`=0.
  - A pending access is dropped; the memory must tolerate `memReq` falling without an ack.

## Timing
- A non-memory instruction spends 1 cycle in E→M and 1 cycle in M→W: `resultW` is valid 2 cycles after the instruction's E cycle.
- A zero-wait memory (ack in the request cycle) adds no stall.
- An ack arriving k cycles after the first request cycle gives `stallM`=1 for exactly k cycles. The W bubble is present during those cycles, and the load data appears on `resultW` in the cycle after the ack.
- Timeout: `stallM`=1 for `TIMEOUT` cycles, then the instruction retires with no write.
- `memAddr`, `memWe`, and `memWData` are stable for every cycle in which `memReq`=1.
- A flush and a stall in the same cycle: the stall wins and the M register holds.

## Test plan
- Reset mid-WAIT (`lw` pending, `rst` pulsed) → all outputs 0 immediately, and the FSM is in IDLE after release.
- ALU op `aluOutE`=0x1234, `regWriteE`=1, `writeRegE`=5 → `aluOutMOut`=0x1234 one cycle later, then `resultW`=0x1234 with `regWriteW`=1 and `writeRegW`=5 in the next cycle; `stallM` stays 0.
- `lw` addr 0x100, ack delayed 3 cycles with `memRData`=0xDEADBEEF → `stallM` high 3 cycles with `memAddr` held at 0x100, then `resultW`=0xDEADBEEF with `regWriteW`=1.
- `sw` addr 0x40, data 0xA5A5A5A5, ack in the same cycle → `memWe`=1, `memWData`=0xA5A5A5A5, no stall, `regWriteW`=0.
- `lw` to addr 0x102 → `memReq` never asserted, `memErr`=1, `regWriteW`=0, no stall.
- `TIMEOUT`=4 with ack never given → `stallM` high 4 cycles, `memErr`=1, then the pipeline resumes with no register write.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of a 5-stage MIPS32 pipeline.
//
// Holds the EX/MEM (M) and MEM/WB (W) pipeline registers and runs a
// variable-latency request/acknowledge handshake towards data memory.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   regWriteE, memToRegE,
//   memWriteE, writeRegE,
//   aluOutE, writeDataE            execute-stage results and control
//   flushE                         load a bubble into M instead of E
//   memReq, memWe, memAddr,
//   memWData                       data-memory request (stable while memReq=1)
//   memRData, memAck               data-memory response
//   stallM                         freezes F/D/E and the M register
//   aluOutMOut, writeRegM,
//   regWriteM, memToRegM           M-stage state for forwarding/hazards
//   writeRegW, regWriteW, resultW  writeback and forwarding
//   memErr                         sticky misalign/timeout flag
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic        memWriteE,
    input  logic [4:0]  writeRegE,
    input  logic [31:0] aluOutE,
    input  logic [31:0] writeDataE,
    input  logic        flushE,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck,
    output logic        stallM,
    output logic [31:0] aluOutMOut,
    output logic [4:0]  writeRegM,
    output logic        regWriteM,
    output logic        memToRegM,
    output logic [4:0]  writeRegW,
    output logic        regWriteW,
    output logic [31:0] resultW,
    output logic        memErr
);

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // M register
    logic        reg_write_m_q,  reg_write_m_d;
    logic        mem_to_reg_m_q, mem_to_reg_m_d;
    logic        mem_write_m_q,  mem_write_m_d;
    logic [4:0]  write_reg_m_q,  write_reg_m_d;
    logic [31:0] alu_out_m_q,    alu_out_m_d;
    logic [31:0] write_data_m_q, write_data_m_d;

    // W register
    logic        reg_write_w_q,  reg_write_w_d;
    logic        mem_to_reg_w_q, mem_to_reg_w_d;
    logic [4:0]  write_reg_w_q,  write_reg_w_d;
    logic [31:0] alu_out_w_q,    alu_out_w_d;
    logic [31:0] read_data_w_q,  read_data_w_d;

    // Handshake FSM and error flag
    state_e      state_q,    state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_err_q,  mem_err_d;

    // ------------------------------------------------------------------
    // M-stage decode
    // ------------------------------------------------------------------
    logic mem_op_m;
    logic misalign_m;
    logic mem_req;
    logic timeout_hit;
    logic ack_valid;
    logic abort;
    logic stall;

    always_comb begin
        mem_op_m    = mem_to_reg_m_q | mem_write_m_q;
        misalign_m  = mem_op_m & (alu_out_m_q[1:0] != 2'b00);
        // The M register holds while stalled, so the request stays stable
        // for its whole lifetime without extra capture flops.
        mem_req     = mem_op_m & ~misalign_m;
        timeout_hit = (state_q == StWait) && (wait_cnt_q == TimeoutCnt);
        // An ack with no request in flight is ignored.
        ack_valid   = mem_req & memAck;
        // An ack in the last allowed cycle still wins over the timeout.
        abort       = mem_req & ~memAck & timeout_hit;
        stall       = mem_req & ~memAck & ~timeout_hit;
    end

    // ------------------------------------------------------------------
    // Handshake FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_req && !memAck) begin
                    state_d    = StWait;
                    wait_cnt_d = 16'd1;
                end
            end
            StWait: begin
                if (memAck || timeout_hit) begin
                    state_d    = StIdle;
                    wait_cnt_d = 16'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline register next state
    // ------------------------------------------------------------------
    always_comb begin
        // Default: hold M (stall wins over flush).
        reg_write_m_d  = reg_write_m_q;
        mem_to_reg_m_d = mem_to_reg_m_q;
        mem_write_m_d  = mem_write_m_q;
        write_reg_m_d  = write_reg_m_q;
        alu_out_m_d    = alu_out_m_q;
        write_data_m_d = write_data_m_q;
        if (!stall) begin
            if (flushE) begin
                reg_write_m_d  = 1'b0;
                mem_to_reg_m_d = 1'b0;
                mem_write_m_d  = 1'b0;
                write_reg_m_d  = 5'd0;
                alu_out_m_d    = 32'd0;
                write_data_m_d = 32'd0;
            end else begin
                reg_write_m_d  = regWriteE;
                mem_to_reg_m_d = memToRegE;
                mem_write_m_d  = memWriteE;
                write_reg_m_d  = writeRegE;
                alu_out_m_d    = aluOutE;
                write_data_m_d = writeDataE;
            end
        end
    end

    always_comb begin
        // Default: bubble into W while the access is outstanding.
        reg_write_w_d  = 1'b0;
        mem_to_reg_w_d = 1'b0;
        write_reg_w_d  = 5'd0;
        alu_out_w_d    = 32'd0;
        read_data_w_d  = 32'd0;
        if (!stall) begin
            // Aborted or misaligned accesses retire without a register write.
            reg_write_w_d  = reg_write_m_q & ~(abort | misalign_m);
            mem_to_reg_w_d = mem_to_reg_m_q;
            write_reg_w_d  = write_reg_m_q;
            alu_out_w_d    = alu_out_m_q;
            read_data_w_d  = ack_valid ? memRData : 32'd0;
        end
    end

    always_comb begin
        mem_err_d = mem_err_q | misalign_m | abort;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            write_reg_m_q  <= 5'd0;
            alu_out_m_q    <= 32'd0;
            write_data_m_q <= 32'd0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            write_reg_w_q  <= 5'd0;
            alu_out_w_q    <= 32'd0;
            read_data_w_q  <= 32'd0;
            state_q        <= StIdle;
            wait_cnt_q     <= 16'd0;
            mem_err_q      <= 1'b0;
        end else begin
            reg_write_m_q  <= reg_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            mem_write_m_q  <= mem_write_m_d;
            write_reg_m_q  <= write_reg_m_d;
            alu_out_m_q    <= alu_out_m_d;
            write_data_m_q <= write_data_m_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            write_reg_w_q  <= write_reg_w_d;
            alu_out_w_q    <= alu_out_w_d;
            read_data_w_q  <= read_data_w_d;
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        memReq     = mem_req;
        // Request fields read as zero when no access is being made.
        memWe      = mem_req & mem_write_m_q;
        memAddr    = mem_req ? alu_out_m_q : 32'd0;
        memWData   = mem_req ? write_data_m_q : 32'd0;
        stallM     = stall;
        aluOutMOut = alu_out_m_q;
        writeRegM  = write_reg_m_q;
        regWriteM  = reg_write_m_q;
        memToRegM  = mem_to_reg_m_q;
        writeRegW  = write_reg_w_q;
        regWriteW  = reg_write_w_q;
        resultW    = mem_to_reg_w_q ? read_data_w_q : alu_out_w_q;
        memErr     = mem_err_q;
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios with literal
// expectations, then randomized instructions and memory latencies checked
// every cycle against a transaction-level model.
module tb_memory_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWriteE, memToRegE, memWriteE, flushE;
    logic [4:0]  writeRegE;
    logic [31:0] aluOutE, writeDataE;
    logic        memReq, memWe, memAck, stallM;
    logic [31:0] memAddr, memWData, memRData;
    logic [31:0] aluOutMOut, resultW;
    logic [4:0]  writeRegM, writeRegW;
    logic        regWriteM, memToRegM, regWriteW, memErr;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .regWriteE  (regWriteE),
        .memToRegE  (memToRegE),
        .memWriteE  (memWriteE),
        .writeRegE  (writeRegE),
        .aluOutE    (aluOutE),
        .writeDataE (writeDataE),
        .flushE     (flushE),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memRData   (memRData),
        .memAck     (memAck),
        .stallM     (stallM),
        .aluOutMOut (aluOutMOut),
        .writeRegM  (writeRegM),
        .regWriteM  (regWriteM),
        .memToRegM  (memToRegM),
        .writeRegW  (writeRegW),
        .regWriteW  (regWriteW),
        .resultW    (resultW),
        .memErr     (memErr)
    );

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] wd;
    } ex_t;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] rd;
    } wb_t;

    // Model state: instruction sitting in M, what W holds, how many cycles the
    // current access has been requesting, its chosen ack latency, sticky error.
    ex_t m;
    wb_t w;
    int  age;
    int  cur_lat;
    bit  err;

    int          forced_lat = -1;
    bit          forced_rd_en = 1'b0;
    logic [31:0] forced_rd = 32'd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m       = '0;
        w       = '0;
        age     = 0;
        cur_lat = 0;
        err     = 1'b0;
    endtask

    function automatic ex_t mk(input logic rw, input logic mtr, input logic mw,
                               input logic [4:0] wr, input logic [31:0] alu,
                               input logic [31:0] wd);
        ex_t e;
        e.rw = rw; e.mtr = mtr; e.mw = mw; e.wr = wr; e.alu = alu; e.wd = wd;
        return e;
    endfunction

    function automatic ex_t rand_instr();
        ex_t e;
        int  k;
        e     = '0;
        k     = $urandom_range(0, 9);
        e.wr  = 5'($urandom);
        e.alu = $urandom;
        e.wd  = $urandom;
        if (k < 4) begin
            e.rw = 1'($urandom);
        end else if (k < 7) begin
            e.rw  = 1'b1;
            e.mtr = 1'b1;
        end else begin
            e.mw = 1'b1;
            e.rw = 1'($urandom);
        end
        if (k >= 4 && $urandom_range(0, 7) != 0) e.alu[1:0] = 2'b00;
        return e;
    endfunction

    // One clock cycle: drive E and the memory response, check every output
    // against the model, then advance the model across the coming edge.
    task automatic cycle(input ex_t e, input bit flush);
        bit          memop, mis, req, ack, abort_now, stall;
        logic [31:0] rd;
        @(negedge clk);
        regWriteE  = e.rw;
        memToRegE  = e.mtr;
        memWriteE  = e.mw;
        writeRegE  = e.wr;
        aluOutE    = e.alu;
        writeDataE = e.wd;
        flushE     = flush;

        memop = m.mtr | m.mw;
        mis   = memop && (m.alu[1:0] != 2'b00);
        req   = memop && !mis;
        if (req && age == 0) begin
            if (forced_lat >= 0) begin
                cur_lat    = forced_lat;
                forced_lat = -1;
            end else begin
                // Latencies beyond TO are never acked and time out.
                cur_lat = int'($urandom_range(0, 6));
            end
        end
        ack = req ? (age == cur_lat) : ($urandom_range(0, 3) == 0);
        rd  = $urandom;
        if (req && ack && forced_rd_en) begin
            rd           = forced_rd;
            forced_rd_en = 1'b0;
        end
        memAck   = ack;
        memRData = rd;
        abort_now = req && !ack && (age == int'(TO));
        stall     = req && !ack && !abort_now;

        #1;
        chk("memReq",     32'(memReq),     32'(req));
        chk("memWe",      32'(memWe),      32'(req && m.mw));
        chk("memAddr",    memAddr,         req ? m.alu : 32'd0);
        chk("memWData",   memWData,        req ? m.wd : 32'd0);
        chk("stallM",     32'(stallM),     32'(stall));
        chk("aluOutMOut", aluOutMOut,      m.alu);
        chk("writeRegM",  32'(writeRegM),  32'(m.wr));
        chk("regWriteM",  32'(regWriteM),  32'(m.rw));
        chk("memToRegM",  32'(memToRegM),  32'(m.mtr));
        chk("writeRegW",  32'(writeRegW),  32'(w.wr));
        chk("regWriteW",  32'(regWriteW),  32'(w.rw));
        chk("resultW",    resultW,         w.mtr ? w.rd : w.alu);
        chk("memErr",     32'(memErr),     32'(err));

        if (stall) begin
            age = age + 1;
            w   = '0;
        end else begin
            w.rw  = m.rw && !(abort_now || mis);
            w.mtr = m.mtr;
            w.wr  = m.wr;
            w.alu = m.alu;
            w.rd  = (req && ack) ? rd : 32'd0;
            m     = flush ? ex_t'('0) : e;
            age   = 0;
        end
        err = err || abort_now || mis;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".memReq"},     32'(memReq),    32'd0);
        chk({tag, ".stallM"},     32'(stallM),    32'd0);
        chk({tag, ".memAddr"},    memAddr,        32'd0);
        chk({tag, ".aluOutMOut"}, aluOutMOut,     32'd0);
        chk({tag, ".regWriteW"},  32'(regWriteW), 32'd0);
        chk({tag, ".resultW"},    resultW,        32'd0);
        chk({tag, ".memErr"},     32'(memErr),    32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        memAck = 1'b0; regWriteE = 1'b0; memToRegE = 1'b0; memWriteE = 1'b0;
        writeRegE = 5'd0; aluOutE = 32'd0; writeDataE = 32'd0; flushE = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam ex_t NOP = '0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        memAck = 1'b0; memRData = 32'd0;
        regWriteE = 1'b0; memToRegE = 1'b0; memWriteE = 1'b0;
        writeRegE = 5'd0; aluOutE = 32'd0; writeDataE = 32'd0; flushE = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // ALU op: M one cycle later, W the cycle after.
        cycle(mk(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0), 1'b0);
        cycle(NOP, 1'b0);
        chk("alu.aluOutMOut", aluOutMOut, 32'h1234);
        chk("alu.stallM", 32'(stallM), 32'd0);
        cycle(NOP, 1'b0);
        chk("alu.resultW", resultW, 32'h1234);
        chk("alu.regWriteW", 32'(regWriteW), 32'd1);
        chk("alu.writeRegW", 32'(writeRegW), 32'd5);

        // Load with ack three cycles after the first request cycle.
        forced_lat = 3; forced_rd = 32'hDEADBEEF; forced_rd_en = 1'b1;
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd9, 32'h100, 32'h0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(NOP, 1'b0);
            chk("lw.stallM", 32'(stallM), 32'd1);
            chk("lw.memAddr", memAddr, 32'h100);
            chk("lw.wbubble", 32'(regWriteW), 32'd0);
        end
        cycle(NOP, 1'b0);
        chk("lw.ackstall", 32'(stallM), 32'd0);
        cycle(NOP, 1'b0);
        chk("lw.resultW", resultW, 32'hDEADBEEF);
        chk("lw.regWriteW", 32'(regWriteW), 32'd1);

        // Store acked in the request cycle.
        forced_lat = 0;
        cycle(mk(1'b0, 1'b0, 1'b1, 5'd0, 32'h40, 32'hA5A5A5A5), 1'b0);
        cycle(NOP, 1'b0);
        chk("sw.memWe", 32'(memWe), 32'd1);
        chk("sw.memWData", memWData, 32'hA5A5A5A5);
        chk("sw.stallM", 32'(stallM), 32'd0);
        cycle(NOP, 1'b0);
        chk("sw.regWriteW", 32'(regWriteW), 32'd0);
        chk("sw.memErr", 32'(memErr), 32'd0);

        // Flushed ALU op never reaches M.
        cycle(mk(1'b1, 1'b0, 1'b0, 5'd3, 32'h77, 32'h0), 1'b1);
        cycle(NOP, 1'b0);
        chk("flush.regWriteM", 32'(regWriteM), 32'd0);

        // Misaligned load.
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd4, 32'h102, 32'h0), 1'b0);
        cycle(NOP, 1'b0);
        chk("mis.memReq", 32'(memReq), 32'd0);
        chk("mis.stallM", 32'(stallM), 32'd0);
        cycle(NOP, 1'b0);
        chk("mis.memErr", 32'(memErr), 32'd1);
        chk("mis.regWriteW", 32'(regWriteW), 32'd0);

        // Timeout with no ack.
        do_reset("rst1");
        forced_lat = 1000;
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd7, 32'h80, 32'h0), 1'b0);
        for (int i = 0; i < int'(TO); i++) begin
            cycle(NOP, 1'b0);
            chk("to.stallM", 32'(stallM), 32'd1);
        end
        cycle(NOP, 1'b0);
        chk("to.abortstall", 32'(stallM), 32'd0);
        chk("to.abortreq", 32'(memReq), 32'd1);
        cycle(NOP, 1'b0);
        chk("to.memReq", 32'(memReq), 32'd0);
        chk("to.regWriteW", 32'(regWriteW), 32'd0);
        chk("to.memErr", 32'(memErr), 32'd1);

        // Reset while a load is waiting, then a zero-wait load must not stall.
        forced_lat = 1000;
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd8, 32'h200, 32'h0), 1'b0);
        cycle(NOP, 1'b0);
        cycle(NOP, 1'b0);
        chk("rw.stallM", 32'(stallM), 32'd1);
        do_reset("rst2");
        forced_lat = 0;
        cycle(mk(1'b1, 1'b1, 1'b0, 5'd8, 32'h204, 32'h0), 1'b0);
        cycle(NOP, 1'b0);
        chk("rw.idle", 32'(stallM), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(rand_instr(), $urandom_range(0, 7) == 0);
            if (i == 1500) do_reset("rst3");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
